// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   state_t  - FSM state encodings. These values appear on the debug state port.
//   OP_*     - opcode field values the controller recognises.
//   ALU_OP_*, SRCB_*, PCSRC_* - datapath select encodings.
//   ctrl_t   - bundle of every control output. It is built combinationally each cycle.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        ALU_WB   = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11,
        FAULT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU     = 2'b00;
    localparam logic [1:0] PCSRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP    = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       fault;
    } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating counter of consecutive memory wait cycles.
//   clk     - system clock, rising edge
//   clr     - asynchronous active-high clear
//   waiting - controller is in a state that holds a memory strobe
//   ready   - memory completed the access this cycle
//   expired - this wait cycle is the TIMEOUT-th consecutive one
//             (combinational, suppressed when ready is high)
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic waiting,
    input  logic ready,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count_reg;
    logic [7:0] count_next;

    // A memory state is left only on ready or on expiry. Clearing on
    // ready or on not-waiting therefore restarts the count on every state change.
    always_comb begin
        count_next = count_reg;
        if (!waiting || ready) begin
            count_next = 8'd0;
        end else if (count_reg != LAST) begin
            count_next = count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_reg <= 8'd0;
        end else begin
            count_reg <= count_next;
        end
    end

    // count_reg holds the waits already completed. This cycle would be wait number TIMEOUT.
    assign expired = waiting & ~ready & (count_reg == LAST);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS controller. It sequences fetch, decode, execute, memory and
// write-back over a single shared memory port.
//   clk, clr            - clock and asynchronous active-high reset
//   opcode              - instruction[31:26] from the instruction register
//   F_zero              - ALU zero flag, used for the beq PC update
//   mem_ready           - shared memory completes the access this cycle
//   pc_en .. pc_source  - datapath enables and selects
//   instr_done          - pulse on the last cycle of each retired instruction
//   fault               - high in the sticky FAULT state
//   state               - current state encoding, for debug
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [5:0] opcode,
    input  logic       F_zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       fault,
    output logic [3:0] state
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;
    logic   pc_write;
    logic   pc_write_cond;
    logic   waiting;
    logic   expired;

    assign waiting = (state_reg == FETCH) || (state_reg == MEM_RD) || (state_reg == MEM_WR);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .clr     (clr),
        .waiting (waiting),
        .ready   (mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        ctrl          = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        state_next    = state_reg;

        case (state_reg)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    pc_write      = 1'b1;
                    state_next    = DECODE;
                end else if (expired) begin
                    state_next = FAULT;
                end
            end
            DECODE: begin
                // The branch target is computed speculatively into ALU out.
                ctrl.alu_src_b = SRCB_SEXT_SH2;
                ctrl.alu_op    = ALU_OP_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_next = MEM_ADDR;
                    OP_RTYPE:     state_next = EXEC;
                    OP_BEQ:       state_next = BRANCH;
                    OP_J:         state_next = JUMP;
                    OP_ADDI:      state_next = ADDI_EX;
                    default:      state_next = FAULT;
                endcase
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
                ctrl.alu_op    = ALU_OP_ADD;
                state_next     = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_next = MEM_WB;
                end else if (expired) begin
                    state_next = FAULT;
                end
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = FETCH;
            end
            MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (mem_ready) begin
                    ctrl.instr_done = 1'b1;
                    state_next      = FETCH;
                end else if (expired) begin
                    state_next = FAULT;
                end
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
                state_next     = ALU_WB;
            end
            ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = FETCH;
            end
            BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alu_op     = ALU_OP_SUB;
                ctrl.pc_source  = PCSRC_ALU_OUT;
                ctrl.instr_done = 1'b1;
                pc_write_cond   = 1'b1;
                state_next      = FETCH;
            end
            JUMP: begin
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
                pc_write        = 1'b1;
                state_next      = FETCH;
            end
            ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
                ctrl.alu_op    = ALU_OP_ADD;
                state_next     = ADDI_WB;
            end
            ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = FETCH;
            end
            FAULT: begin
                ctrl.fault = 1'b1;
                state_next = FAULT;
            end
            default: begin
                // Encodings 12..14 are unreachable. If one appears, stop safely.
                state_next = FAULT;
            end
        endcase

        ctrl.pc_en = pc_write | (pc_write_cond & F_zero);

        // While clr is high, every strobe is forced off. An aborted
        // instruction therefore issues no writes.
        if (clr) begin
            ctrl       = '0;
            state_next = FETCH;
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign i_or_d     = ctrl.i_or_d;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_source  = ctrl.pc_source;
    assign instr_done = ctrl.instr_done;
    assign fault      = ctrl.fault;
    assign state      = state_reg;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Finite-state controller that sequences the MIPS datapath as a multi-cycle machine sharing one memory_unit between instruction fetch and data access. Each cycle it decodes the current opcode and state, then drives the datapath's register enables, mux selects and memory strobes. It waits on a memory ready handshake and enters a sticky fault state on an illegal opcode or a memory timeout. It sits beside processor_control_unit's role in the top level and replaces its per-instruction combinational decode.

## Interface
- TIMEOUT, 16: maximum cycles a memory strobe may wait for mem_ready before FAULT; legal range 2..255.
- clk  in  1  system clock, rising-edge.
- clr  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- F_zero  in  1  ALU zero flag.
- mem_ready  in  1  shared memory has completed the current read/write this cycle.
- pc_en  out  1  PC load: pc_write | (pc_write_cond & F_zero).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU out register.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  register write address: 0 = rt, 1 = rd.
- mem_to_reg  out  1  register write data: 0 = ALU out, 1 = memory data register.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B: 00 = register B, 01 = constant 4, 10 = sign-ext, 11 = sign-ext<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct.
- pc_source  out  2  00 = ALU result, 01 = ALU out register, 10 = jump target.
- instr_done  out  1  one-cycle pulse on the last cycle of each retired instruction.
- fault  out  1  high while in FAULT.
- state  out  4  current state encoding, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000. Any other opcode in DECODE goes to FAULT.
- States and encodings:
  - FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. When mem_ready=1, also ir_write=1 and pc_write=1, then go to DECODE; otherwise stay in FETCH.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00, to precompute the branch target. Dispatch: lw/sw to MEM_ADDR, R-type to EXEC, beq to BRANCH, j to JUMP, addi to ADDI_EX.
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_RD for lw, MEM_WR for sw.
  - MEM_RD(3): mem_read=1, i_or_d=1. Go to MEM_WB on mem_ready.
  - MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Go to FETCH.
  - MEM_WR(5): mem_write=1, i_or_d=1. When mem_ready=1, instr_done=1 and go to FETCH.
  - EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALU_WB.
  - ALU_WB(7): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Go to FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Go to FETCH.
  - JUMP(9): pc_write=1, pc_source=10, instr_done=1. Go to FETCH.
  - ADDI_EX(10): alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDI_WB.
  - ADDI_WB(11): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Go to FETCH.
  - FAULT(15): all strobes and enables 0, fault=1. Left only by clr.
- Any output not listed for a state is 0 in that state.
- Wait timer: counts consecutive cycles spent in FETCH, MEM_RD or MEM_WR with mem_ready=0, and clears whenever the state changes.
  - A cycle in which the count would reach TIMEOUT goes to FAULT.
  - mem_ready=1 in that same cycle wins: complete normally, no FAULT.
- Unused encodings 12–14 go to FAULT on the next clock.

## Timing
- clr high: state=FETCH, timer=0, every output 0, overriding the combinational decode. Asserting clr mid-instruction aborts it with no writes issued.
- First cycle after clr falls: FETCH with mem_read=1.
- State and timer are registered. Outputs are combinational from state; pc_en, ir_write and instr_done also depend on mem_ready/F_zero in the same cycle.
- Latency in cycles with zero wait states: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4. Each cycle mem_ready is low in a memory state adds exactly one cycle.
- mem_read and mem_write are never high together. The memory strobe stays high, with its address held, until mem_ready.

## Structure
- Package mc_ctrl_pkg holds:
  - state_t enum with the fixed encodings above;
  - opcode constants;
  - alu_op, alu_src_b and pc_source encoding constants.
- Sub-module mem_wait_timer (parameter TIMEOUT; inputs clk, clr, waiting, ready; output expired) contains the saturating wait counter.
- Top-level FSM: one always_ff for the state register, one always_comb for next-state and outputs.

## Test plan
- Reset: clr pulsed mid-MEM_RD → all outputs 0 during clr; after release state=0 and mem_read=1.
- R-type with mem_ready tied 1 → states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in cycle 4; instr_done exactly once.
- lw with mem_ready low for 3 cycles in MEM_RD → 8 cycles total; mem_read and i_or_d=1 held through the wait; reg_write with mem_to_reg=1 in the final cycle.
- beq with F_zero=1, then beq with F_zero=0 → pc_en=1 with pc_source=01 in the BRANCH cycle of the first; pc_en=0 in the BRANCH cycle of the second.
- opcode 111111 in DECODE → FAULT next cycle, fault=1 and stays 1 for 20 cycles; mem_ready toggling has no effect.
- TIMEOUT=4 with mem_ready held 0 in FETCH → FAULT after the 4th wait cycle. Repeat with mem_ready=1 on the 4th cycle → DECODE, no fault.
